// File: rtl/pe_mem_pkg.sv
// Shared definitions for the PE memory subsystem: default data width,
// the PE memory map and the byte-address to word-index helper.
package pe_mem_pkg;

  localparam int MEMORY_WIDTH_DEFAULT = 32;

  localparam logic [31:0] BOOT_START     = 32'h0000_0000;
  localparam logic [31:0] BOOT_END       = 32'h1FFF_FFFF;
  localparam logic [31:0] RAM_START      = 32'h4000_0000;
  localparam logic [31:0] RAM_END        = 32'h5FFF_FFFF;
  localparam logic [31:0] PERIPH_START   = 32'hE100_0000;
  localparam logic [31:0] PERIPH_END     = 32'hE1FF_FFFF;
  localparam logic [31:0] PRINTCHAR_ADDR = 32'hF000_00D0;

  // Drops the byte offset and everything above the RAM capacity, so the
  // window wraps modulo the RAM size.
  function automatic logic [63:0] word_index(input logic [63:0] byte_addr,
                                             input int msize_log2,
                                             input int lane_log2);
    logic [63:0] mask;
    mask = (64'd1 << (msize_log2 - lane_log2)) - 64'd1;
    return (byte_addr >> lane_log2) & mask;
  endfunction

endpackage

// File: rtl/pe_ram_port.sv
// One access port of the PE scratchpad: byte-lane write enables and the
// registered read-data output with asynchronous clear.
module pe_ram_port #(
  parameter int WIDTH = 32,
  parameter int LANES = WIDTH / 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [LANES-1:0] wb,
  input  logic [WIDTH-1:0] rd_word,
  output logic [LANES-1:0] we,
  output logic [WIDTH-1:0] data_out
);

  // Reset gates the strobes so an access overlapping reset never lands.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign we[gi] = enable & wb[gi] & ~reset;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out <= '0;
    end else if (enable) begin
      data_out <= rd_word;
    end
  end

endmodule

// File: rtl/pe_dual_port_ram.sv
// True dual-port byte-writable scratchpad for one PE. Port A is the DMA
// side, port B the CPU side; both share one array and one clock.
module pe_dual_port_ram
  import pe_mem_pkg::*;
#(
  parameter int    MEMORY_WIDTH = MEMORY_WIDTH_DEFAULT,
  parameter int    RAM_MSIZE    = 65536,
  parameter int    ADDRESS      = 0,
  parameter string INIT_FILE    = ""
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      a_enable_in,
  input  logic [MEMORY_WIDTH-1:0]   a_addr_in,
  input  logic [MEMORY_WIDTH-1:0]   a_data_in,
  input  logic [MEMORY_WIDTH/8-1:0] a_wb_in,
  output logic [MEMORY_WIDTH-1:0]   a_data_out,
  input  logic                      b_enable_in,
  input  logic [MEMORY_WIDTH-1:0]   b_addr_in,
  input  logic [MEMORY_WIDTH-1:0]   b_data_in,
  input  logic [MEMORY_WIDTH/8-1:0] b_wb_in,
  output logic [MEMORY_WIDTH-1:0]   b_data_out
);

  localparam int LANES      = MEMORY_WIDTH / 8;
  localparam int LANE_LOG2  = $clog2(LANES);
  localparam int MSIZE_LOG2 = $clog2(RAM_MSIZE);
  localparam int WORDS      = RAM_MSIZE / LANES;
  localparam int AW         = MSIZE_LOG2 - LANE_LOG2;

  logic [MEMORY_WIDTH-1:0] mem [WORDS];

  logic [AW-1:0]           a_idx;
  logic [AW-1:0]           b_idx;
  logic [LANES-1:0]        a_we;
  logic [LANES-1:0]        b_we;
  logic [MEMORY_WIDTH-1:0] a_rd_word;
  logic [MEMORY_WIDTH-1:0] b_rd_word;

  always_comb begin
    a_idx = AW'(word_index(64'(a_addr_in), MSIZE_LOG2, LANE_LOG2));
    b_idx = AW'(word_index(64'(b_addr_in), MSIZE_LOG2, LANE_LOG2));
  end

  // Combinational fetch of the pre-write word; the port registers it,
  // which gives read-first behaviour on both ports.
  assign a_rd_word = mem[a_idx];
  assign b_rd_word = mem[b_idx];

  initial begin
    for (int w = 0; w < WORDS; w++) begin
      mem[w] = '0;
    end
  end

  // Port B's assignment comes last, so it owns any lane both ports strobe
  // on the same word.
  always_ff @(posedge clock) begin
    for (int i = 0; i < LANES; i++) begin
      if (a_we[i]) mem[a_idx][i*8 +: 8] <= a_data_in[i*8 +: 8];
      if (b_we[i]) mem[b_idx][i*8 +: 8] <= b_data_in[i*8 +: 8];
    end
  end

  pe_ram_port #(.WIDTH(MEMORY_WIDTH), .LANES(LANES)) u_port_a (
    .clock    (clock),
    .reset    (reset),
    .enable   (a_enable_in),
    .wb       (a_wb_in),
    .rd_word  (a_rd_word),
    .we       (a_we),
    .data_out (a_data_out)
  );

  pe_ram_port #(.WIDTH(MEMORY_WIDTH), .LANES(LANES)) u_port_b (
    .clock    (clock),
    .reset    (reset),
    .enable   (b_enable_in),
    .wb       (b_wb_in),
    .rd_word  (b_rd_word),
    .we       (b_we),
    .data_out (b_data_out)
  );

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (!a_enable_in && |a_wb_in)
      $warning("pe %0d port A: strobes 0x%0h with enable low", ADDRESS, a_wb_in);
    if (!b_enable_in && |b_wb_in)
      $warning("pe %0d port B: strobes 0x%0h with enable low", ADDRESS, b_wb_in);
  end
`endif

endmodule

// File: tb/tb_pe_dual_port_ram.sv
// Scoreboard bench for pe_dual_port_ram: stimulus queues expected read data,
// a monitor pops and compares one cycle after each enabled access.
module tb_pe_dual_port_ram;

  logic        clock = 1'b0;
  logic        reset;
  logic        a_enable_in, b_enable_in;
  logic [31:0] a_addr_in, a_data_in, b_addr_in, b_data_in;
  logic [3:0]  a_wb_in, b_wb_in;
  logic [31:0] a_data_out, b_data_out;

  typedef struct {
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   fails  = 0;
  logic a_pend, b_pend;
  exp_t ea, eb;

  always #5 clock = ~clock;

  pe_dual_port_ram dut (
    .clock       (clock),
    .reset       (reset),
    .a_enable_in (a_enable_in),
    .a_addr_in   (a_addr_in),
    .a_data_in   (a_data_in),
    .a_wb_in     (a_wb_in),
    .a_data_out  (a_data_out),
    .b_enable_in (b_enable_in),
    .b_addr_in   (b_addr_in),
    .b_data_in   (b_data_in),
    .b_wb_in     (b_wb_in),
    .b_data_out  (b_data_out)
  );

  // Monitor: an enabled, non-reset edge means a read result is due.
  always @(posedge clock) begin
    a_pend = a_enable_in && !reset;
    b_pend = b_enable_in && !reset;
    #1;
    if (a_pend) begin
      checks++;
      if (qa.size() == 0) begin
        fails++;
        $display("FAIL unexpected_read_a: a_data_out=%h, required no pending read", a_data_out);
      end else begin
        ea = qa.pop_front();
        if (a_data_out !== ea.data) begin
          fails++;
          $display("FAIL %s: a_data_out=%h required %h", ea.name, a_data_out, ea.data);
        end else
          $display("ok   %s: a_data_out=%h", ea.name, a_data_out);
      end
    end
    if (b_pend) begin
      checks++;
      if (qb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_read_b: b_data_out=%h, required no pending read", b_data_out);
      end else begin
        eb = qb.pop_front();
        if (b_data_out !== eb.data) begin
          fails++;
          $display("FAIL %s: b_data_out=%h required %h", eb.name, b_data_out, eb.data);
        end else
          $display("ok   %s: b_data_out=%h", eb.name, b_data_out);
      end
    end
  end

  task automatic step(input logic ae, input logic [31:0] aa, input logic [31:0] ad,
                      input logic [3:0] aw, input logic [31:0] aexp, input string an,
                      input logic be, input logic [31:0] ba, input logic [31:0] bd,
                      input logic [3:0] bw, input logic [31:0] bexp, input string bn);
    exp_t e;
    a_enable_in = ae; a_addr_in = aa; a_data_in = ad; a_wb_in = aw;
    b_enable_in = be; b_addr_in = ba; b_data_in = bd; b_wb_in = bw;
    if (ae) begin e.data = aexp; e.name = an; qa.push_back(e); end
    if (be) begin e.data = bexp; e.name = bn; qb.push_back(e); end
    @(negedge clock);
  endtask

  task automatic check_now(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end else
      $display("ok   %s: %h", name, got);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    a_enable_in = 0; a_addr_in = 0; a_data_in = 0; a_wb_in = 0;
    b_enable_in = 0; b_addr_in = 0; b_data_in = 0; b_wb_in = 0;
    #7;
    check_now("reset_a_out", a_data_out, 32'h0);
    check_now("reset_b_out", b_data_out, 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    step(1, 32'h0, 0, 4'h0, 32'h0, "rd0_a",
         1, 32'h0, 0, 4'h0, 32'h0, "rd0_b");
    step(1, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, "wr10_a_readfirst",
         1, 32'h0000_0010, 0, 4'h0, 32'h0, "xport_old_b");
    step(1, 32'h4000_0010, 0, 4'h0, 32'hDEAD_BEEF, "rd10_a",
         1, 32'h0000_0010, 0, 4'h0, 32'hDEAD_BEEF, "rd10_b");
    step(1, 32'h20, 32'h1122_3344, 4'hF, 32'h0, "preset20_a",
         0, 0, 0, 4'h0, 0, "");
    step(0, 0, 0, 4'h0, 0, "",
         1, 32'h20, 32'hAABB_CCDD, 4'b0101, 32'h1122_3344, "strobe20_b_readfirst");
    step(1, 32'h20, 0, 4'h0, 32'h11BB_33DD, "rd20_a",
         0, 0, 0, 4'h0, 0, "");
    step(1, 32'h30, 32'h0101_0101, 4'hF, 32'h0, "coll30_a",
         1, 32'h30, 32'h0202_0202, 4'h3, 32'h0, "coll30_b");
    step(1, 32'h30, 0, 4'h0, 32'h0101_0202, "rd30_a",
         1, 32'h30, 0, 4'h0, 32'h0101_0202, "rd30_b");
    step(0, 32'h30, 32'hFFFF_FFFF, 4'hF, 0, "",
         0, 32'h30, 32'hFFFF_FFFF, 4'hF, 0, "");
    check_now("disabled_hold_a", a_data_out, 32'h0101_0202);
    check_now("disabled_hold_b", b_data_out, 32'h0101_0202);
    step(1, 32'h30, 0, 4'h0, 32'h0101_0202, "rd30_after_disabled_a",
         0, 0, 0, 4'h0, 0, "");
    step(1, 32'h0001_0004, 32'h1234_5678, 4'hF, 32'h0, "wrap_wr_a",
         0, 0, 0, 4'h0, 0, "");
    step(1, 32'h4001_0004, 0, 4'h0, 32'h1234_5678, "wrap_rd_a",
         1, 32'h0000_0004, 0, 4'h0, 32'h1234_5678, "wrap_rd_b");

    // Reset pulse straddling an edge with a write pending.
    a_enable_in = 1; a_addr_in = 32'h4; a_data_in = 32'hCAFE_F00D; a_wb_in = 4'hF;
    b_enable_in = 0; b_wb_in = 4'h0;
    #2 reset = 1'b1;
    #1;
    check_now("async_reset_a", a_data_out, 32'h0);
    check_now("async_reset_b", b_data_out, 32'h0);
    @(negedge clock);
    check_now("reset_held_a", a_data_out, 32'h0);
    reset = 1'b0;
    step(1, 32'h0, 0, 4'h0, 32'h0, "post_reset_rd0_a",
         1, 32'h4, 0, 4'h0, 32'h1234_5678, "post_reset_rd4_b");
    step(0, 0, 0, 4'h0, 0, "", 0, 0, 0, 4'h0, 0, "");

    checks++;
    if (qa.size() + qb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", qa.size() + qb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
